// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, reset PC default,
// instruction field positions and fetch queue depth.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } fetchStateT;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned QUEUE_DEPTH = 2;

    function automatic logic [OP_MSB-OP_LSB:0] opField(input logic [INSTR_W-1:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Two-entry synchronous FIFO holding fetched {pc, instruction} pairs; supports
// simultaneous push/pop and a single-cycle flush.
module instr_fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] pushData,
    output logic [DATA_W-1:0] headData,
    output logic [1:0]        count
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [1:0] FULL = 2'(QUEUE_DEPTH);

    logic [DATA_W-1:0] mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  headQ;
    logic [PTR_W-1:0]  tailQ;
    logic [1:0]        countQ;
    logic              doPush;
    logic              doPop;

    assign doPop  = pop && (countQ != 2'd0);
    assign doPush = push && ((countQ != FULL) || doPop);

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= 2'd0;
        end else if (flush) begin
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= 2'd0;
        end else begin
            if (doPush) begin
                mem[tailQ] <= pushData;
                tailQ      <= tailQ + PTR_W'(1);
            end
            if (doPop) begin
                headQ <= headQ + PTR_W'(1);
            end
            countQ <= countQ + 2'(doPush) - 2'(doPop);
        end
    end

    assign headData = mem[headQ];
    assign count    = countQ;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, 2-entry fetch queue and
// redirect handling. Optional stall counter enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [5:0]        op,
    output logic [ADDR_W-1:0] instr_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    fetchStateT        stateQ, stateD;
    logic [ADDR_W-1:0] pcQ, pcD;
    logic              killQ, killD;
    logic              inflightQ, inflightD;
    logic              pushEn;
    logic              popEn;
    logic [1:0]        count;
    logic [2:0]        countAfter;
    logic [ENTRY_W-1:0] headEntry;

    instr_fetch_queue #(
        .DATA_W   (ENTRY_W),
        .RESET_VAL({RESET_PC, 32'h0000_0000})
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect_valid),
        .push    (pushEn),
        .pop     (popEn),
        .pushData({pcQ, imem_rdata}),
        .headData(headEntry),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= StIdle;
            pcQ       <= RESET_PC;
            killQ     <= 1'b0;
            inflightQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            pcQ       <= pcD;
            killQ     <= killD;
            inflightQ <= inflightD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        pcD        = pcQ;
        killD      = killQ;
        inflightD  = inflightQ;
        pushEn     = 1'b0;
        popEn      = (count != 2'd0) && instr_ready && !redirect_valid;
        countAfter = 3'(count) - 3'(popEn);
        if (redirect_valid) begin
            pcD = {redirect_pc[ADDR_W-1:2], 2'b00};
            // A response arriving in the redirect cycle is simply dropped; otherwise mark it.
            if (stateQ == StWait && !imem_valid) begin
                killD = 1'b1;
            end else begin
                stateD    = StReq;
                killD     = 1'b0;
                inflightD = 1'b0;
            end
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if ((3'(count) + 3'(inflightQ)) < 3'(QUEUE_DEPTH)) begin
                        stateD = StReq;
                    end
                end
                StReq: begin
                    stateD    = StWait;
                    inflightD = 1'b1;
                end
                StWait: begin
                    if (imem_valid) begin
                        if (!killQ) begin
                            pushEn = 1'b1;
                            pcD    = pcQ + ADDR_W'(4);
                        end
                        killD      = 1'b0;
                        inflightD  = 1'b0;
                        countAfter = 3'(count) + 3'(pushEn) - 3'(popEn);
                        stateD     = (countAfter < 3'(QUEUE_DEPTH)) ? StReq : StIdle;
                    end
                end
                default: stateD = StIdle;
            endcase
        end
    end

    // Request is withheld in a redirect cycle so a stale address never goes out.
    always_comb begin
        imem_req    = (stateQ == StReq) && !redirect_valid;
        imem_addr   = pcQ;
        instr_valid = (count != 2'd0);
        instr       = headEntry[INSTR_W-1:0];
        op          = opField(headEntry[INSTR_W-1:0]);
        instr_pc    = headEntry[ENTRY_W-1:INSTR_W];
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stallCntQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCntQ <= 32'd0;
        end else if (!instr_valid && !redirect_valid && (stallCntQ != 32'hFFFF_FFFF)) begin
            stallCntQ <= stallCntQ + 32'd1;
        end
    end

    assign stall_cnt = stallCntQ;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: behavioural memory plus an instruction-stream scoreboard,
// directed scenarios followed by randomized redirects, backpressure and memory latency.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    instr_fetch #(
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .op            (op),
        .instr_pc      (instr_pc),
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    // Scoreboard: expected queue contents (by pc) and the single memory transaction.
    logic [31:0] modelPc[$];
    logic [31:0] reqLog[$];
    logic [31:0] fetchPc;
    bit          outstanding;
    bit          outKilled;
    logic [31:0] outAddr;
    int          outRem;
    int          latMin = 1;
    int          latMax = 1;
    int          spurPct = 0;
    bit          spurOnce;
    int          idleCnt;
    bit          lastReq;
    logic [31:0] lastAddr;
    logic [31:0] stallExp;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic stepCycle(input bit redir, input logic [31:0] rtarget, input bit ready);
        bit          vld;
        logic [31:0] rd;
        vld = 1'b0;
        rd  = $urandom;
        if (outstanding && outRem == 0) begin
            vld = 1'b1;
            rd  = memWord(outAddr);
        end else if (!outstanding && (spurOnce || ($urandom_range(99) < spurPct))) begin
            vld = 1'b1;
        end
        spurOnce       = 1'b0;
        redirect_valid = redir;
        redirect_pc    = rtarget;
        instr_ready    = ready;
        imem_valid     = vld;
        imem_rdata     = rd;
        #1;
        lastReq  = imem_req;
        lastAddr = imem_addr;

        checkEq("instr_valid", instr_valid, modelPc.size() != 0);
        if (modelPc.size() != 0) begin
            checkEq("instr_pc", instr_pc, modelPc[0]);
            checkEq("instr", instr, memWord(modelPc[0]));
            checkEq("op", op, memWord(modelPc[0]) >> 26);
        end
        if (imem_req) begin
            reqLog.push_back(imem_addr);
            checkEq("one_outstanding", outstanding, 0);
            checkEq("credit", modelPc.size() <= 1, 1);
            checkEq("req_addr", imem_addr, fetchPc);
            checkEq("req_in_redirect", redir, 0);
        end
        if (imem_req || outstanding || modelPc.size() >= 2 || redir) begin
            idleCnt = 0;
        end else begin
            idleCnt++;
            if (idleCnt >= 3) begin
                checkEq("liveness_idle", idleCnt, 2);
                idleCnt = 0;
            end
        end
`ifdef FETCH_PERF_CNT_EN
        checkEq("stall_cnt", stall_cnt, stallExp);
        if (modelPc.size() == 0 && !redir && stallExp != 32'hFFFF_FFFF) stallExp++;
`endif

        if (modelPc.size() != 0 && ready && !redir) void'(modelPc.pop_front());
        if (vld && outstanding) begin
            if (!outKilled && !redir) begin
                modelPc.push_back(outAddr);
                fetchPc = outAddr + 32'd4;
            end
            outstanding = 1'b0;
        end
        if (redir) begin
            modelPc.delete();
            fetchPc = {rtarget[31:2], 2'b00};
            if (outstanding) outKilled = 1'b1;
        end
        if (outstanding) outRem--;
        if (imem_req) begin
            outstanding = 1'b1;
            outKilled   = 1'b0;
            outAddr     = imem_addr;
            outRem      = $urandom_range(latMax, latMin) - 1;
        end
        @(negedge clk);
    endtask

    task automatic resetDut(input bit spur, input bit ready);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        imem_valid     = 1'b0;
        #1;
        checkEq("rst_imem_req", imem_req, 0);
        checkEq("rst_imem_addr", imem_addr, 32'h0);
        checkEq("rst_instr_valid", instr_valid, 0);
        checkEq("rst_instr", instr, 32'h0);
        checkEq("rst_op", op, 6'h0);
        checkEq("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        checkEq("rst_stall_cnt", stall_cnt, 32'h0);
`endif
        modelPc.delete();
        reqLog.delete();
        fetchPc     = 32'h0;
        outstanding = 1'b0;
        outKilled   = 1'b0;
        idleCnt     = 0;
        stallExp    = 32'h0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        spurOnce = spur;
        stepCycle(1'b0, 32'h0, ready);
        checkEq("first_req_early", lastReq, 0);
        stepCycle(1'b0, 32'h0, ready);
        checkEq("first_req", lastReq, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        rst_n          = 1'b0;
        imem_valid     = 1'b0;
        imem_rdata     = 32'h0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        spurOnce       = 1'b0;
        @(negedge clk);

        // Sequential fetch with single-cycle memory and a consumer always ready.
        latMin = 1; latMax = 1;
        resetDut(1'b0, 1'b1);
        repeat (10) stepCycle(1'b0, 32'h0, 1'b1);
        checkEq("seq_count", reqLog.size() >= 4, 1);
        for (int i = 0; i < 4 && i < reqLog.size(); i++) checkEq("seq_addr", reqLog[i], i * 4);

        // Backpressure: queue fills to two entries and fetching stops.
        resetDut(1'b0, 1'b0);
        repeat (8) stepCycle(1'b0, 32'h0, 1'b0);
        checkEq("bp_reqs", reqLog.size(), 2);
        checkEq("bp_head_pc", instr_pc, 32'h0);
        guard = 0;
        do begin
            stepCycle(1'b0, 32'h0, 1'b1);
            guard++;
        end while (!lastReq && guard < 10);
        checkEq("bp_resume_addr", lastAddr, 32'h8);

        // Redirect while a request is pending: response dropped, fetch resumes at aligned target.
        latMin = 3; latMax = 3;
        resetDut(1'b0, 1'b1);
        stepCycle(1'b1, 32'h0000_0043, 1'b1);
        checkEq("redir_valid_drop", instr_valid, 0);
        guard = 0;
        do begin
            stepCycle(1'b0, 32'h0, 1'b1);
            guard++;
        end while (!lastReq && guard < 10);
        checkEq("redir_addr", lastAddr, 32'h40);
        repeat (10) stepCycle(1'b0, 32'h0, 1'b1);

        // Push and pop in the same cycle with one entry held.
        latMin = 1; latMax = 1;
        resetDut(1'b0, 1'b0);
        guard = 0;
        while (!(outstanding && outRem == 0 && modelPc.size() == 1) && guard < 20) begin
            stepCycle(1'b0, 32'h0, 1'b0);
            guard++;
        end
        stepCycle(1'b0, 32'h0, 1'b1);
        checkEq("pushpop_valid", instr_valid, 1);
        checkEq("pushpop_pc", instr_pc, 32'h4);

        // Reset in the middle of a transaction, then a stray response while idle.
        latMin = 3; latMax = 3;
        resetDut(1'b0, 1'b1);
        stepCycle(1'b0, 32'h0, 1'b1);
        resetDut(1'b1, 1'b1);
        repeat (10) stepCycle(1'b0, 32'h0, 1'b1);
        checkEq("rst_refetch_addr", reqLog[0], 32'h0);

        // Randomized traffic: variable latency, backpressure, redirects, stray responses.
        latMin = 1; latMax = 4; spurPct = 5;
        resetDut(1'b0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            bit          redir;
            logic [31:0] tgt;
            redir = ($urandom_range(99) < 3);
            tgt   = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15)) : $urandom;
            stepCycle(redir, tgt, ($urandom_range(99) < 70));
        end
        spurPct = 0;

        // Fixed three-cycle latency with a consumer always ready.
        latMin = 3; latMax = 3;
        resetDut(1'b0, 1'b1);
        repeat (40) stepCycle(1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
